z80_io_uart_tx: RTL and testbench

- Z80 I/O-space responder that accepts OUT cycles from the CPU core and serializes the bytes as 8N1 UART on TXD.
- Write data is buffered in a 4-entry FIFO.
- A status register is readable with IN for software polling.
- Sits inside z80_mini_com on the CPU I/O bus; all bus signals are synchronous to CLK50M.

---
 rtl/z80_io_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_z80_io_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_uart_tx.sv
// ============================================================================
// z80_io_uart_tx : Z80 I/O-port UART transmitter (8N1) with a 4-byte write FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module z80_io_uart_tx #(
   parameter logic [7:0]  BASE_ADDR = 8'h00,
   parameter int unsigned BAUD_DIV  = 434
) (
   input  logic       CLK50M,
   input  logic       n_RST,
   input  logic       n_IORQ,
   input  logic       n_RD,
   input  logic       n_WR,
   input  logic [7:0] ADDR,
   input  logic [7:0] DATA_IN,
   output logic [7:0] DATA_OUT,
   output logic       DATA_OE,
   output logic       TXD
);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [7:0]  STAT_ADDR = BASE_ADDR + 8'd1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic       wr_act, rd_act;
   logic       push, push_ok, pop;
   logic       full, empty, tx_idle;
   logic       wr_q, rd_q;
   logic       ovf_q, ovf_d;
   logic [7:0] fifo_q [4];
   logic [1:0] wptr_q, rptr_q;
   logic [2:0] count_q, count_d;

   state_t     state_q;
   logic [15:0] baud_q;
   logic [2:0] bit_q;
   logic [7:0] shift_q;
   logic       txd_q;

   assign wr_act  = !n_IORQ && !n_WR && (ADDR == BASE_ADDR);
   assign rd_act  = !n_IORQ && !n_RD && (ADDR == STAT_ADDR);
   // Edge-detect the strobe so a long-held write pushes exactly once
   assign push    = wr_act && !wr_q;
   assign full    = (count_q == 3'd4);
   assign empty   = (count_q == 3'd0);
   assign pop     = (state_q == S_IDLE) && !empty;
   assign push_ok = push && (!full || pop);
   assign tx_idle = empty && (state_q == S_IDLE);

   assign DATA_OE  = rd_act;
   assign DATA_OUT = rd_act ? {5'b0, ovf_q, tx_idle, !full} : 8'h00;
   assign TXD      = txd_q;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop)
         count_d = count_q + 3'd1;
      else if (!push_ok && pop)
         count_d = count_q - 3'd1;

      ovf_d = ovf_q;
      if (push && !push_ok)
         ovf_d = 1'b1;
      else if (rd_q && !rd_act)
         ovf_d = 1'b0;
   end

   always_ff @(posedge CLK50M or negedge n_RST) begin
      if (!n_RST) begin
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         ovf_q   <= 1'b0;
         wptr_q  <= 2'd0;
         rptr_q  <= 2'd0;
         count_q <= 3'd0;
      end else begin
         wr_q    <= wr_act;
         rd_q    <= rd_act;
         ovf_q   <= ovf_d;
         count_q <= count_d;
         if (push_ok)
            wptr_q <= wptr_q + 2'd1;
         if (pop)
            rptr_q <= rptr_q + 2'd1;
      end
   end

   always_ff @(posedge CLK50M) begin
      if (push_ok)
         fifo_q[wptr_q] <= DATA_IN;
   end

   // TXD is a registered copy of the current state's line level, one cycle behind
   always_ff @(posedge CLK50M or negedge n_RST) begin
      if (!n_RST) begin
         state_q <= S_IDLE;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         txd_q   <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shift_q <= fifo_q[rptr_q];
                  baud_q  <= BAUD_LAST;
                  state_q <= S_START;
               end
            end
            S_START: begin
               txd_q <= 1'b0;
               if (baud_q == 16'd0) begin
                  baud_q  <= BAUD_LAST;
                  bit_q   <= 3'd0;
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
            S_DATA: begin
               txd_q <= shift_q[0];
               if (baud_q == 16'd0) begin
                  baud_q <= BAUD_LAST;
                  if (bit_q == 3'd7) begin
                     state_q <= S_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= {1'b0, shift_q[7:1]};
                  end
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
            S_STOP: begin
               txd_q <= 1'b1;
               if (baud_q == 16'd0)
                  state_q <= S_IDLE;
               else
                  baud_q <= baud_q - 16'd1;
            end
            default: begin
               txd_q   <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_z80_io_uart_tx.sv
// ============================================================================
// tb_z80_io_uart_tx : directed self-checking bench for z80_io_uart_tx (BAUD_DIV=4)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_z80_io_uart_tx;

   logic       clk    = 1'b0;
   logic       n_rst  = 1'b0;
   logic       n_iorq = 1'b1;
   logic       n_rd   = 1'b1;
   logic       n_wr   = 1'b1;
   logic [7:0] addr   = 8'h00;
   logic [7:0] din    = 8'h00;
   logic [7:0] dout;
   logic       oe;
   logic       txd;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   z80_io_uart_tx #(
      .BASE_ADDR (8'h00),
      .BAUD_DIV  (4)
   ) dut (
      .CLK50M   (clk),
      .n_RST    (n_rst),
      .n_IORQ   (n_iorq),
      .n_RD     (n_rd),
      .n_WR     (n_wr),
      .ADDR     (addr),
      .DATA_IN  (din),
      .DATA_OUT (dout),
      .DATA_OE  (oe),
      .TXD      (txd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_pulse(input logic [7:0] a, input logic [7:0] d);
      n_iorq = 1'b0; n_wr = 1'b0; addr = a; din = d;
      tick();
      n_iorq = 1'b1; n_wr = 1'b1;
      tick();
   endtask

   task automatic rd_status(input string tag, input logic [7:0] exp);
      logic [7:0] d;
      logic       o;
      n_iorq = 1'b0; n_rd = 1'b0; addr = 8'h01;
      #1;
      d = dout;
      o = oe;
      tick();
      n_iorq = 1'b1; n_rd = 1'b1;
      check({tag, "_data"}, d, exp);
      check({tag, "_oe"}, o, 1);
   endtask

   task automatic wait_fall(input string tag, output int n);
      n = 0;
      while (txd !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      check(tag, txd, 0);
   endtask

   // Called with TXD expected to have just fallen; checks all 40 bit-cycles
   task automatic check_frame(input string tag, input logic [7:0] b);
      logic [9:0] fb;
      fb = {1'b1, b, 1'b0};
      for (int c = 0; c < 40; c++) begin
         check($sformatf("%s_c%0d", tag, c), txd, fb[c/4]);
         tick();
      end
   endtask

   task automatic count_lows(input string tag, input int cycles);
      int lows;
      lows = 0;
      for (int i = 0; i < cycles; i++) begin
         if (txd !== 1'b1) lows++;
         tick();
      end
      check(tag, lows, 0);
   endtask

   // Write with a 3-cycle strobe and check the exact N+2 start-bit latency
   task automatic tx_exact(input string tag, input logic [7:0] b);
      n_iorq = 1'b0; n_wr = 1'b0; addr = 8'h00; din = b;
      tick();
      check({tag, "_latN"}, txd, 1);
      tick();
      check({tag, "_latN1"}, txd, 1);
      tick();
      n_iorq = 1'b1; n_wr = 1'b1;
      check_frame(tag, b);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;

      repeat (3) @(posedge clk);
      #1;
      check("rst_txd", txd, 1);
      check("rst_dout", dout, 8'h00);
      check("rst_oe", oe, 0);
      n_rst = 1'b1;
      tick();
      rd_status("rst_status", 8'h03);
      tick();

      tx_exact("t1", 8'h55);
      rd_status("t1_status", 8'h03);
      tick();

      n_iorq = 1'b0; n_wr = 1'b0; addr = 8'h00; din = 8'hA5;
      fork
         begin
            repeat (20) tick();
            n_iorq = 1'b1; n_wr = 1'b1;
         end
         begin
            int m;
            wait_fall("t2_fall", m);
            check("t2_lat", m, 3);
            check_frame("t2", 8'hA5);
         end
      join
      count_lows("t2_single_frame", 60);
      rd_status("t2_status", 8'h03);
      tick();

      fork
         begin
            for (int k = 1; k <= 6; k++) wr_pulse(8'h00, 8'(k));
            rd_status("t3_ovf", 8'h04);
            tick();
            rd_status("t3_ovf_clr", 8'h00);
         end
         begin
            int m;
            wait_fall("t3_fall1", m);
            check_frame("t3_b1", 8'h01);
            for (int k = 2; k <= 5; k++) begin
               wait_fall($sformatf("t3_fall%0d", k), m);
               check($sformatf("t3_gap%0d", k), m, 1);
               check_frame($sformatf("t3_b%0d", k), 8'(k));
            end
         end
      join
      count_lows("t3_no_sixth", 60);
      rd_status("t3_end_status", 8'h03);
      tick();

      n_iorq = 1'b0; n_wr = 1'b0; addr = 8'h02; din = 8'h77;
      tick();
      tick();
      n_iorq = 1'b1; n_wr = 1'b1;
      tick();
      n_iorq = 1'b0; n_rd = 1'b0; addr = 8'h00;
      #1;
      check("t4_rd_base_oe", oe, 0);
      check("t4_rd_base_dout", dout, 8'h00);
      tick();
      n_iorq = 1'b1; n_rd = 1'b1;
      count_lows("t4_txd_idle", 50);
      rd_status("t4_status", 8'h03);
      tick();

      for (int k = 0; k < 5; k++) wr_pulse(8'h00, 8'hA0 + 8'(k));
      rd_status("t5_full", 8'h00);
      repeat (40) tick();
      rd_status("t5_after_pop", 8'h01);
      repeat (180) tick();
      rd_status("t5_drained", 8'h03);
      tick();

      wr_pulse(8'h00, 8'hF0);
      wait_fall("t6_fall", n);
      repeat (9) tick();
      check("t6_pre_rst_txd", txd, 0);
      #3;
      n_rst = 1'b0;
      #1;
      check("t6_async_txd", txd, 1);
      check("t6_rst_oe", oe, 0);
      check("t6_rst_dout", dout, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      check("t6_hold_txd", txd, 1);
      rd_status("t6_rst_status", 8'h03);
      n_rst = 1'b1;
      tick();
      tx_exact("t6", 8'h0F);
      rd_status("t6_end_status", 8'h03);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
